// File: rtl/axi_rdata_strb_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rdata_strb_pipe_if
// Description : AXI R-channel bundle feeding axi_rdata_strb_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rdata_strb_pipe_if #(
    parameter int AXI_IDW      = 4,
    parameter int AXI_DATA_WID = 256
);
    logic                    i_rlast;
    logic [AXI_DATA_WID-1:0] i_rdata;
    logic                    i_rvalid;
    logic [AXI_IDW-1:0]      i_rid;
    logic [1:0]              i_rresp;
    logic                    o_rready;

    modport master (
        output i_rlast, i_rdata, i_rvalid, i_rid, i_rresp,
        input  o_rready
    );

    modport slave (
        input  i_rlast, i_rdata, i_rvalid, i_rid, i_rresp,
        output o_rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_rdata_strb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : axi_rdata_strb_pipe
// Description : AXI R-channel to rdata FIFO stage with per-transfer burst
//               tracking, byte-strobe generation and a 2-entry output buffer.
//               Optional macro RID_CHECK_EN enables RID mismatch detection.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rdata_strb_pipe #(
    parameter int AXI_IDW      = 4,
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_STRBW    = AXI_DATA_WID / 8,
    parameter int OFFW         = $clog2(AXI_STRBW),
    parameter int CNTW         = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    trans_start,
    input  logic [CNTW-1:0]         trans_burst_num,
    input  logic [AXI_IDW-1:0]      trans_rid,
    input  logic [OFFW-1:0]         strb_first_beat_num,
    input  logic [OFFW-1:0]         strb_last_beat_num,
    output logic                    trans_busy,
    output logic                    trans_done,
    output logic                    trans_err,
    output logic [1:0]              err_resp,
    axi_rdata_strb_pipe_if.slave    axi_r,
    input  logic                    rdata_fifo_full_s,
    output logic                    rdata_fifo_push,
    output logic [AXI_DATA_WID-1:0] rdata_fifo_data_s,
    output logic [AXI_STRBW-1:0]    rdata_fifo_strb_s,
    output logic                    rdata_fifo_last_s,
    output logic                    axi_burst_rdata_ok
);
    localparam logic [1:0]           ST_IDLE     = 2'd0;
    localparam logic [1:0]           ST_RECV     = 2'd1;
    localparam logic [1:0]           ST_DRAIN    = 2'd2;
    localparam logic [AXI_STRBW-1:0] c_strb_ones = '1;
    localparam logic [AXI_STRBW-1:0] c_strb_one  = AXI_STRBW'(1);
    localparam logic [CNTW-1:0]      c_cnt_one   = CNTW'(1);

    logic [1:0]              r_state;
    logic [CNTW-1:0]         r_burst_rem;
    logic                    r_first_pend;
    logic [OFFW-1:0]         r_first_num;
    logic [OFFW-1:0]         r_last_num;
    logic                    r_zero_done;
    logic                    r_trans_err;
    logic [1:0]              r_err_resp;
    logic [AXI_DATA_WID-1:0] r_buf_data [2];
    logic [AXI_STRBW-1:0]    r_buf_strb [2];
    logic [1:0]              r_buf_last;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_buf_cnt;

    logic                    w_rready;
    logic                    w_beat_ok;
    logic                    w_burst_end;
    logic                    w_xfer_last;
    logic                    w_head_valid;
    logic                    w_push;
    logic                    w_final_push;
    logic [AXI_STRBW-1:0]    w_first_mask;
    logic [AXI_STRBW-1:0]    w_last_mask;
    logic [AXI_STRBW-1:0]    w_beat_strb;
    logic                    w_resp_err;
    logic                    w_rid_err;
    logic                    w_beat_err;
    logic [1:0]              w_beat_resp;

    assign w_rready     = (r_state == ST_RECV) & (r_buf_cnt != 2'd2);
    assign w_beat_ok    = axi_r.i_rvalid & w_rready;
    assign w_burst_end  = axi_r.i_rlast & w_beat_ok;
    assign w_xfer_last  = axi_r.i_rlast & (r_burst_rem == c_cnt_one);
    assign w_head_valid = (r_buf_cnt != 2'd0);
    assign w_push       = w_head_valid & ~rdata_fifo_full_s;
    // Only DRAIN can empty the buffer for the last time: no accepts happen there.
    assign w_final_push = (r_state == ST_DRAIN) & w_push & (r_buf_cnt == 2'd1);

    assign w_first_mask = c_strb_ones << r_first_num;
    assign w_last_mask  = (r_last_num == '0) ? c_strb_ones
                                             : ((c_strb_one << r_last_num) - c_strb_one);

    always_comb begin
        w_beat_strb = c_strb_ones;
        if (r_first_pend) begin
            w_beat_strb = w_beat_strb & w_first_mask;
        end
        if (w_xfer_last) begin
            w_beat_strb = w_beat_strb & w_last_mask;
        end
    end

`ifdef RID_CHECK_EN
    logic [AXI_IDW-1:0] r_rid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rid <= '0;
        end else if ((r_state == ST_IDLE) && trans_start) begin
            r_rid <= trans_rid;
        end
    end

    assign w_rid_err = (axi_r.i_rid != r_rid);
`else
    logic w_unused_rid;
    assign w_unused_rid = ^{trans_rid, axi_r.i_rid};
    assign w_rid_err    = 1'b0;
`endif

    assign w_resp_err  = (axi_r.i_rresp != 2'b00);
    assign w_beat_err  = w_beat_ok & (w_resp_err | w_rid_err);
    assign w_beat_resp = w_resp_err ? axi_r.i_rresp : 2'b10;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_burst_rem  <= '0;
            r_first_pend <= 1'b0;
            r_first_num  <= '0;
            r_last_num   <= '0;
            r_zero_done  <= 1'b0;
            r_trans_err  <= 1'b0;
            r_err_resp   <= 2'b00;
        end else begin
            r_zero_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trans_start) begin
                        if (trans_burst_num == '0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_state      <= ST_RECV;
                            r_burst_rem  <= trans_burst_num;
                            r_first_pend <= 1'b1;
                            r_first_num  <= strb_first_beat_num;
                            r_last_num   <= strb_last_beat_num;
                            r_trans_err  <= 1'b0;
                            r_err_resp   <= 2'b00;
                        end
                    end
                end
                ST_RECV: begin
                    if (w_beat_ok) begin
                        r_first_pend <= 1'b0;
                    end
                    if (w_burst_end) begin
                        r_burst_rem <= r_burst_rem - c_cnt_one;
                        if (w_xfer_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    if (w_beat_err) begin
                        r_trans_err <= 1'b1;
                        if (!r_trans_err) begin
                            r_err_resp <= w_beat_resp;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_final_push) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_buf_cnt <= 2'd0;
        end else begin
            if (w_beat_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_push) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_beat_ok, w_push})
                2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge aclk) begin
        if (w_beat_ok) begin
            r_buf_data[r_wr_ptr] <= axi_r.i_rdata;
            r_buf_strb[r_wr_ptr] <= w_beat_strb;
            r_buf_last[r_wr_ptr] <= w_xfer_last;
        end
    end

    assign axi_r.o_rready     = w_rready;
    assign axi_burst_rdata_ok = w_burst_end;
    assign rdata_fifo_push    = w_push;
    assign rdata_fifo_data_s  = r_buf_data[r_rd_ptr] & {AXI_DATA_WID{w_head_valid}};
    assign rdata_fifo_strb_s  = r_buf_strb[r_rd_ptr] & {AXI_STRBW{w_head_valid}};
    assign rdata_fifo_last_s  = r_buf_last[r_rd_ptr] & w_head_valid;
    assign trans_busy         = (r_state != ST_IDLE);
    assign trans_done         = r_zero_done | w_final_push;
    assign trans_err          = r_trans_err;
    assign err_resp           = r_err_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi_rdata_strb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rdata_strb_pipe
// Description : Self-checking bench for axi_rdata_strb_pipe (RID_CHECK_EN off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rdata_strb_pipe;
    localparam int IDW = 4;
    localparam int DW  = 256;
    localparam int SW  = DW / 8;
    localparam int OW  = $clog2(SW);
    localparam int CW  = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          trans_start = 1'b0;
    logic [CW-1:0] trans_burst_num = '0;
    logic [IDW-1:0] trans_rid = '0;
    logic [OW-1:0] first_num = '0;
    logic [OW-1:0] last_num = '0;
    logic          trans_busy, trans_done, trans_err;
    logic [1:0]    err_resp;
    logic          full = 1'b0;
    logic          push;
    logic [DW-1:0] fdata;
    logic [SW-1:0] fstrb;
    logic          flast;
    logic          rok;

    axi_rdata_strb_pipe_if #(.AXI_IDW(IDW), .AXI_DATA_WID(DW)) bus ();

    axi_rdata_strb_pipe #(
        .AXI_IDW(IDW), .AXI_DATA_WID(DW), .AXI_STRBW(SW), .OFFW(OW), .CNTW(CW)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .trans_start        (trans_start),
        .trans_burst_num    (trans_burst_num),
        .trans_rid          (trans_rid),
        .strb_first_beat_num(first_num),
        .strb_last_beat_num (last_num),
        .trans_busy         (trans_busy),
        .trans_done         (trans_done),
        .trans_err          (trans_err),
        .err_resp           (err_resp),
        .axi_r              (bus),
        .rdata_fifo_full_s  (full),
        .rdata_fifo_push    (push),
        .rdata_fifo_data_s  (fdata),
        .rdata_fifo_strb_s  (fstrb),
        .rdata_fifo_last_s  (flast),
        .axi_burst_rdata_ok (rok)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, done_cnt = 0, ok_cnt = 0, acc_cnt = 0, viol = 0;
    int full_mode = 0;
    logic [DW-1:0] cap_data [$];
    logic [SW-1:0] cap_strb [$];
    bit            cap_last [$];
    bit            cap_done [$];
    int            cap_cyc  [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(posedge aclk) cyc++;

    always @(posedge aclk) begin
        #1;
        full = (full_mode == 2) ? 1'b1 : (full_mode == 1) ? ($urandom_range(99) < 30) : 1'b0;
    end

    always @(negedge aclk) begin
        if (push) begin
            cap_data.push_back(fdata);
            cap_strb.push_back(fstrb);
            cap_last.push_back(flast);
            cap_done.push_back(trans_done);
            cap_cyc.push_back(cyc);
        end
        if (trans_done) done_cnt++;
        if (rok) ok_cnt++;
        if (bus.i_rvalid && bus.o_rready) acc_cnt++;
        if (bus.o_rready && !trans_busy) viol++;
    end

    // Reference strobe built bit by bit from the offset rules.
    function automatic logic [SW-1:0] model_strb(int k, int n, int first, int last);
        logic [SW-1:0] m;
        m = '1;
        for (int b = 0; b < SW; b++) begin
            if (k == 0 && b < first) m[b] = 1'b0;
            if (k == n - 1 && last != 0 && b >= last) m[b] = 1'b0;
        end
        return m;
    endfunction

    task automatic run_transfer(input int nb, input int bpb, input int first, input int last,
                                input int gap_pct, input int err_mode, input bit restart);
        int n, d0, o0, guard;
        logic [DW-1:0] exp_data [$];
        logic [1:0]    rr [$];
        logic [1:0]    exp_resp, r;
        bit            exp_err;
        n = nb * bpb;
        exp_err = 1'b0;
        exp_resp = 2'b00;
        for (int k = 0; k < n; k++) begin
            exp_data.push_back({$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom});
            if (err_mode == 1)      r = (k == 2) ? 2'b10 : (k == 5) ? 2'b11 : 2'b00;
            else if (err_mode == 2) r = ($urandom_range(7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            else                    r = 2'b00;
            rr.push_back(r);
            if (r != 2'b00 && !exp_err) begin
                exp_err = 1'b1;
                exp_resp = r;
            end
        end
        cap_data.delete(); cap_strb.delete(); cap_last.delete(); cap_done.delete(); cap_cyc.delete();
        d0 = done_cnt;
        o0 = ok_cnt;
        @(posedge aclk); #1;
        trans_start = 1'b1;
        trans_burst_num = CW'(nb);
        first_num = OW'(first);
        last_num = OW'(last);
        trans_rid = IDW'($urandom);
        @(posedge aclk); #1;
        trans_start = 1'b0;
        first_num = OW'($urandom);
        last_num = OW'($urandom);
        trans_burst_num = CW'($urandom);
        for (int k = 0; k < n; k++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.i_rvalid = 1'b0;
                @(posedge aclk); #1;
            end
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = exp_data[k];
            bus.i_rlast  = ((k % bpb) == bpb - 1);
            bus.i_rresp  = rr[k];
            bus.i_rid    = IDW'($urandom);
            trans_start  = restart && (k == 1);
            guard = 0;
            forever begin
                @(negedge aclk);
                if (bus.o_rready) break;
                guard++;
                if (guard > 300) break;
            end
            if (guard > 300) begin
                chk("accept_timeout", 1, 0);
                bus.i_rvalid = 1'b0;
                trans_start = 1'b0;
                return;
            end
            @(posedge aclk); #1;
            trans_start = 1'b0;
        end
        bus.i_rvalid = 1'b0;
        bus.i_rlast  = 1'b0;
        bus.i_rresp  = 2'b00;
        guard = 0;
        while (done_cnt == d0 && guard < 1000) begin
            @(negedge aclk);
            guard++;
        end
        @(negedge aclk);
        chk("done_once", done_cnt - d0, 1);
        chk("push_count", cap_data.size(), n);
        for (int k = 0; k < n && k < cap_data.size(); k++) begin
            chk($sformatf("data[%0d]", k), cap_data[k], exp_data[k]);
            chk($sformatf("strb[%0d]", k), cap_strb[k], model_strb(k, n, first, last));
            chk($sformatf("last[%0d]", k), cap_last[k], (k == n - 1));
            chk($sformatf("done_at[%0d]", k), cap_done[k], (k == n - 1));
        end
        chk("rdata_ok_count", ok_cnt - o0, nb);
        chk("trans_err", trans_err, exp_err);
        chk("err_resp", err_resp, exp_resp);
        chk("busy_after", trans_busy, 0);
    endtask

    typedef struct {
        int nb; int bpb; int first; int last;
        logic [SW-1:0] exp_first;
        logic [SW-1:0] exp_final;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, a0;
        vecs[0] = '{1, 1,  4, 12, 32'h00000FF0, 32'h00000FF0};
        vecs[1] = '{3, 4,  8,  0, 32'hFFFFFF00, 32'hFFFFFFFF};
        vecs[2] = '{2, 2,  0,  5, 32'hFFFFFFFF, 32'h0000001F};
        vecs[3] = '{1, 3, 31,  1, 32'h80000000, 32'h00000001};
        vecs[4] = '{1, 1, 31,  0, 32'h80000000, 32'h80000000};
        vecs[5] = '{1, 1,  3,  3, 32'h00000000, 32'h00000000};
        vecs[6] = '{2, 1, 16, 16, 32'hFFFF0000, 32'h0000FFFF};

        bus.i_rvalid = 1'b0; bus.i_rlast = 1'b0; bus.i_rdata = '0;
        bus.i_rid = '0; bus.i_rresp = 2'b00;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", trans_busy, 0);
        chk("rst_done", trans_done, 0);
        chk("rst_err", trans_err, 0);
        chk("rst_err_resp", err_resp, 0);
        chk("rst_rready", bus.o_rready, 0);
        chk("rst_push", push, 0);
        chk("rst_strb", fstrb, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            run_transfer(vecs[i].nb, vecs[i].bpb, vecs[i].first, vecs[i].last, 0, 0, 1'b0);
            if (cap_strb.size() > 0) begin
                chk($sformatf("vec%0d_first_strb", i), cap_strb[0], vecs[i].exp_first);
                chk($sformatf("vec%0d_final_strb", i), cap_strb[cap_strb.size()-1], vecs[i].exp_final);
            end
        end

        // FIFO held full: only two beats absorbed, then back-to-back drain
        full_mode = 2;
        a0 = acc_cnt;
        fork
            run_transfer(1, 6, 0, 0, 0, 0, 1'b0);
            begin
                repeat (12) @(negedge aclk);
                chk("full_absorbed", acc_cnt - a0, 2);
                chk("full_rready", bus.o_rready, 0);
                full_mode = 0;
            end
        join
        if (cap_cyc.size() == 6) chk("full_b2b_pushes", cap_cyc[5] - cap_cyc[0], 5);
        else chk("full_b2b_size", cap_cyc.size(), 6);

        // Error capture then clearing on the next transfer
        run_transfer(1, 6, 2, 9, 0, 1, 1'b0);
        run_transfer(2, 2, 1, 3, 0, 0, 1'b0);

        // Zero-burst transfer
        @(posedge aclk); #1;
        d0 = done_cnt;
        trans_start = 1'b1;
        trans_burst_num = '0;
        @(negedge aclk);
        chk("zero_done_early", trans_done, 0);
        @(posedge aclk); #1;
        trans_start = 1'b0;
        @(negedge aclk);
        chk("zero_done", trans_done, 1);
        chk("zero_busy", trans_busy, 0);
        chk("zero_rready", bus.o_rready, 0);
        @(negedge aclk);
        chk("zero_done_once", done_cnt - d0, 1);

        // trans_start while busy is ignored
        run_transfer(2, 3, 6, 20, 0, 0, 1'b1);

        // Asynchronous reset with the buffer full
        full_mode = 2;
        @(posedge aclk); #1;
        trans_start = 1'b1; trans_burst_num = CW'(2); first_num = '0; last_num = '0;
        @(posedge aclk); #1;
        trans_start = 1'b0;
        bus.i_rvalid = 1'b1; bus.i_rlast = 1'b0; bus.i_rresp = 2'b01;
        bus.i_rdata = {8{32'hA5A5_5A5A}};
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        chk("pre_rst_rready", bus.o_rready, 0);
        chk("pre_rst_err", trans_err, 1);
        chk("pre_rst_strb", fstrb, 32'hFFFFFFFF);
        d0 = done_cnt;
        #2 aresetn = 1'b0;
        #1;
        chk("arst_busy", trans_busy, 0);
        chk("arst_rready", bus.o_rready, 0);
        chk("arst_err", trans_err, 0);
        chk("arst_err_resp", err_resp, 0);
        chk("arst_data", fdata, 0);
        chk("arst_strb", fstrb, 0);
        bus.i_rvalid = 1'b0; bus.i_rresp = 2'b00;
        full_mode = 0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        chk("arst_no_done", done_cnt - d0, 0);
        run_transfer(2, 3, 5, 7, 0, 0, 1'b0);

        // Randomised transfers against the model
        full_mode = 1;
        for (int t = 0; t < 25; t++) begin
            run_transfer($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(0, SW - 1),
                         $urandom_range(0, SW - 1), 20, 2, 1'($urandom_range(0, 1)));
        end
        full_mode = 0;

        chk("rready_outside_busy", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_rdata_strb_pipe.md
Name: axi_rdata_strb_pipe

Overview:
- Parametrised successor to the iDMA AXI read-data processor. Sits between the AXI R channel and the rdata FIFO.
- Owns the per-transfer burst count internally, so callers no longer drive first/last-burst flags.
- Generates byte strobes for any data width, including transfers that are a single beat.
- Adds a 2-entry output buffer, an end-of-transfer marker, a done pulse, and RRESP error capture.

Parameters:
AXI_IDW, 4, RID width
AXI_DATA_WID, 256, R data width in bits; power of two, 64..1024
AXI_STRBW, AXI_DATA_WID/8, strobe width
OFFW, $clog2(AXI_STRBW), width of byte-offset fields
CNTW, 16, width of burst-count field

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
trans_start  input  1  one-cycle pulse; loads descriptor
trans_burst_num  input  CNTW  number of AXI bursts in the transfer
trans_rid  input  AXI_IDW  expected RID (used only under RID_CHECK_EN)
strb_first_beat_num  input  OFFW  byte offset of first valid byte in first beat
strb_last_beat_num  input  OFFW  valid bytes in last beat; 0 means full beat
trans_busy  output  1  state != IDLE
trans_done  output  1  one-cycle pulse, coincident with the final FIFO push
trans_err  output  1  sticky error flag
err_resp  output  2  RRESP of the first erroring beat
i_rlast  input  1  AXI RLAST
i_rdata  input  AXI_DATA_WID  AXI RDATA
i_rvalid  input  1  AXI RVALID
i_rid  input  AXI_IDW  AXI RID
i_rresp  input  2  AXI RRESP
o_rready  output  1  AXI RREADY
rdata_fifo_full_s  input  1  downstream FIFO full
rdata_fifo_push  output  1  FIFO write enable
rdata_fifo_data_s  output  AXI_DATA_WID  beat data
rdata_fifo_strb_s  output  AXI_STRBW  beat byte strobe
rdata_fifo_last_s  output  1  beat is the last beat of the transfer
axi_burst_rdata_ok  output  1  RLAST handshake (combinational)

Behaviour:
- Reset values: state IDLE; buffer empty; all outputs 0.
- States: IDLE, RECV, DRAIN.
  - IDLE -> RECV on trans_start with trans_burst_num != 0. Latch the descriptor, set burst_rem = trans_burst_num, set first_pend = 1, clear trans_err and err_resp.
  - trans_start with trans_burst_num == 0: trans_done pulses the next cycle; state stays IDLE.
  - trans_start is ignored outside IDLE.
  - RECV -> DRAIN when the RLAST handshake occurs with burst_rem == 1.
  - DRAIN -> IDLE on the cycle the final buffered beat is pushed; trans_done pulses in that same cycle.
- Handshake rules:
  - beat_ok = i_rvalid & o_rready.
  - o_rready = (state == RECV) & (buf_cnt != 2). It is never asserted in IDLE or DRAIN.
  - burst_rem decrements on each i_rlast & beat_ok.
  - axi_burst_rdata_ok = i_rlast & beat_ok.
- Strobe, computed when the beat is accepted and stored with it:
  - first_mask = all-ones << strb_first_beat_num.
  - last_mask = all-ones if strb_last_beat_num == 0, else (1 << strb_last_beat_num) - 1.
  - First beat of the transfer (first_pend) uses first_mask; first_pend clears after it.
  - Last beat (RLAST with burst_rem == 1) uses last_mask.
  - A beat that is both first and last uses first_mask & last_mask.
  - All other beats use all-ones.
  - All mask arithmetic is done at AXI_STRBW width; no hard-coded 32-bit constants.
- Buffer: 2-entry FIFO holding {data, strb, last}.
  - rdata_fifo_push = (buf_cnt != 0) & ~rdata_fifo_full_s.
  - Output fields come from the head entry, combinationally.
  - Latency: a beat accepted in cycle N is pushed in cycle N+1 at the earliest.
  - A push and an accept in the same cycle leave buf_cnt unchanged.
  - With the FIFO full, at most 2 beats are absorbed, then o_rready deasserts.
- Errors:
  - Any accepted beat with i_rresp != 0 sets trans_err.
  - err_resp captures the RRESP of the first such beat only.
  - The beat's data is still forwarded.
- Reset mid-transfer: all state clears immediately (asynchronous); no done pulse is generated.

Optional Feature:
RID_CHECK_EN
- Defined: an accepted beat with i_rid != latched trans_rid sets trans_err and sets err_resp = 2'b10 if no error has been recorded yet. The beat is still forwarded.
- Undefined: i_rid and trans_rid are ignored; no comparison logic is built.

Test Plan:
- Single beat, 1 burst, first=4, last=12, FIFO never full -> one push; strb = 0x00000FF0 at 256-bit width; last_s=1; trans_done in the same cycle as the push.
- 3 bursts x 4 beats, first=8, last=0 -> 12 pushes; strb0 = 0xFFFFFF00, beats 1..11 = 0xFFFFFFFF; last_s only on beat 11; axi_burst_rdata_ok 3 times.
- FIFO full held 10 cycles while rvalid=1 -> exactly 2 beats accepted, then o_rready=0; on release, pushes resume back-to-back with no beat lost or reordered.
- RRESP=SLVERR on beat 2 and DECERR on beat 5 -> trans_err=1; err_resp=2'b10; all beats pushed; flags clear on the next trans_start.
- trans_burst_num=0 -> no o_rready; trans_done the next cycle. trans_start while busy -> ignored, counters unaffected.
- aresetn low mid-burst (buf_cnt=2) -> all outputs 0 asynchronously; after release, a new transfer completes correctly.
